nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder. Feeds one 4-bit RippleCarryAdder stage a nibble per cycle.
//   Takes that stage's sum/carry each cycle, registers the carry and assembles the full result.
//   Used where area matters more than latency, e.g. round-counter/key-schedule arithmetic.
//   Valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH   32   operand/result width in bits; must be a multiple of 4 and >= 4
//   (derived) N = WIDTH/4 nibble steps; CNT_W = max(1,$clog2(N))
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a + b + cin, low WIDTH bits
//   cout       out  1      carry-out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async assert, sync release)
//     state=IDLE; a_sh, b_sh, sum, carry, cnt all 0.
//     out_valid=0, cout=0, in_ready=1, busy=0.
//   FSM IDLE
//     in_ready=1.
//     in_valid&&in_ready: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0 -> RUN.
//   FSM RUN
//     Stage inputs: A=a_sh[3:0], B=b_sh[3:0], Cin=carry.
//     Each edge: sum<={Sum,sum[WIDTH-1:4]}; carry<=Cout; a_sh,b_sh>>=4; cnt++.
//     cnt==N-1 -> DONE.
//   FSM DONE
//     out_valid=1; sum and cout(=carry) held stable.
//     out_valid&&out_ready -> IDLE; out_valid drops next edge.
//   Latency
//     Accept at edge E; out_valid high after edge E+N. Minimum period N+2 cycles/op.
//   in_ready=(state==IDLE) only. in_valid in RUN/DONE is ignored; no input is latched.
//   out_ready low in DONE: hold indefinitely; no output change.
//   out_ready outside DONE has no effect.
//   Wrap-around: sum is modulo 2^WIDTH; overflow reported only on cout.
//   Reset mid-RUN/DONE: operation discarded, no out_valid pulse; outputs as reset.
//   WIDTH=4: single RUN cycle, identical result to one RippleCarryAdder pass.
//   X-free: all registers reset; sum is undefined-free even before the first op.
// STRUCTURE
//   Shared package adder_pkg
//     NIBBLE_W=4.
//     State encoding ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10; 2'b11 -> IDLE.
//   One sub-module instance: RippleCarryAdder (4-bit combinational stage), no changes.
//   Remainder is in-module: FSM, counter, shift registers.
// TESTING (WIDTH=16 unless stated; out_ready=1 unless stated)
//   1. a=16'hFFFF, b=16'h0001, cin=0
//      -> sum=16'h0000, cout=1; out_valid 4 edges after accept.
//   2. a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
//      Then a=16'h8000, b=16'h8000, cin=0 back-to-back -> sum=16'h0000, cout=1.
//   3. Backpressure: hold out_ready=0 for 3 cycles in DONE
//      -> out_valid, sum, cout stable; in_ready=0; in_valid pulses with new data ignored.
//   4. Assert rst_n=0 on 2nd RUN cycle
//      -> out_valid=0, sum=0, cout=0, in_ready=1 asynchronously; next op a=1, b=2 -> sum=3.
//   5. WIDTH=32: a=32'hFFFFFFFF, b=32'hFFFFFFFF, cin=1
//      -> sum=32'hFFFFFFFF, cout=1, latency 8.
//   6. WIDTH=4: a=4'h9, b=4'h8, cin=1 -> sum=4'h2, cout=1, latency 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: stage width and FSM encoding.
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic int nib_steps(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/RippleCarryAdder.sv
// Four-bit combinational ripple-carry stage reused once per nibble step.
module RippleCarryAdder
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] Sum,
   output logic                Cout
);

   logic [NIBBLE_W:0] w_c;

   assign w_c[0] = Cin;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
         assign Sum[gi]    = A[gi] ^ B[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
      end
   endgenerate

   assign Cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared 4-bit stage.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | one nibble added per edge, carry held in r_carry
// DONE    | result presented, held until out_ready
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int N     = nib_steps(WIDTH);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;

   logic [NIBBLE_W-1:0] w_stage_sum;
   logic                w_stage_cout;
   logic [WIDTH-1:0]    w_sum_next;

   RippleCarryAdder u_stage (
      .A    (r_a_sh[NIBBLE_W-1:0]),
      .B    (r_b_sh[NIBBLE_W-1:0]),
      .Cin  (r_carry),
      .Sum  (w_stage_sum),
      .Cout (w_stage_cout)
   );

   // New nibble enters at the top; after N steps the first nibble lands at bit 0.
   generate
      if (WIDTH == NIBBLE_W) begin : g_single
         assign w_sum_next = w_stage_sum;
      end else begin : g_multi
         assign w_sum_next = {w_stage_sum, r_sum[WIDTH-1:NIBBLE_W]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a_sh     <= a;
                  r_b_sh     <= b;
                  r_carry    <= cin;
                  r_cnt      <= '0;
                  r_state    <= ST_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_stage_cout;
               r_a_sh  <= r_a_sh >> NIBBLE_W;
               r_b_sh  <= r_b_sh >> NIBBLE_W;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_carry;
   assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH 16, 32 and 4.
module tb_nibble_serial_adder;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_ready;
   int          sel;

   logic        rdy16, ov16, co16, bz16;
   logic [15:0] s16;
   logic        rdy32, ov32, co32, bz32;
   logic [31:0] s32;
   logic        rdy4, ov4, co4, bz4;
   logic [3:0]  s4;

   logic        cur_ready, cur_valid, cur_cout, cur_busy;
   logic [31:0] cur_sum;
   int          cur_w;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy16),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(ov16), .out_ready(out_ready),
      .sum(s16), .cout(co16), .busy(bz16));

   nibble_serial_adder #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy32),
      .a(a), .b(b), .cin(cin), .out_valid(ov32), .out_ready(out_ready),
      .sum(s32), .cout(co32), .busy(bz32));

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy4),
      .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(ov4), .out_ready(out_ready),
      .sum(s4), .cout(co4), .busy(bz4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      cur_ready = rdy16;
      cur_valid = ov16;
      cur_cout  = co16;
      cur_busy  = bz16;
      cur_sum   = {16'h0, s16};
      cur_w     = 16;
      if (sel == 1) begin
         cur_ready = rdy32; cur_valid = ov32; cur_cout = co32; cur_busy = bz32;
         cur_sum = s32; cur_w = 32;
      end else if (sel == 2) begin
         cur_ready = rdy4; cur_valid = ov4; cur_cout = co4; cur_busy = bz4;
         cur_sum = {28'h0, s4}; cur_w = 4;
      end
   end

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      exp_t        e;
      logic [32:0] full;
      logic [32:0] mask;
      int          guard = 0;
      while (!cur_ready && guard < 40) begin
         tick();
         guard++;
      end
      check("in_ready_before_accept", {32'h0, cur_ready}, 33'h1);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mask   = (33'h1 << cur_w) - 33'h1;
      full   = (av & mask) + (bv & mask) + {32'h0, cv};
      e.sum  = 32'(full & mask);
      e.cout = full[cur_w];
      e.lat  = cur_w / 4;
      q.push_back(e);
   endtask

   task automatic wait_result;
      exp_t e;
      int   lat = 0;
      while (!cur_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("out_valid_seen", {32'h0, cur_valid}, 33'h1);
      if (q.size() == 0) begin
         check("scoreboard_nonempty", 33'h0, 33'h1);
      end else begin
         e = q.pop_front();
         check("latency", 33'(lat), 33'(e.lat));
         check("sum", {1'b0, cur_sum}, {1'b0, e.sum});
         check("cout", {32'h0, cur_cout}, {32'h0, e.cout});
      end
   endtask

   task automatic finish_op;
      out_ready = 1'b1;
      tick();
      check("out_valid_drop", {32'h0, cur_valid}, 33'h0);
      check("in_ready_after", {32'h0, cur_ready}, 33'h1);
   endtask

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      start_op(av, bv, cv);
      wait_result();
      finish_op();
   endtask

   initial begin
      logic [31:0] held_sum;
      logic        held_cout;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      out_ready = 1'b1; sel = 0;
      #12;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         check("rst_out_valid", {32'h0, cur_valid}, 33'h0);
         check("rst_sum", {1'b0, cur_sum}, 33'h0);
         check("rst_cout", {32'h0, cur_cout}, 33'h0);
         check("rst_in_ready", {32'h0, cur_ready}, 33'h1);
         check("rst_busy", {32'h0, cur_busy}, 33'h0);
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op(32'hFFFF, 32'h0001, 1'b0);
      run_op(32'h1234, 32'h4321, 1'b1);
      run_op(32'h8000, 32'h8000, 1'b0);

      // Backpressure: result held while out_ready is low, new operands ignored.
      out_ready = 1'b0;
      start_op(32'hA5A5, 32'h0F0F, 1'b1);
      wait_result();
      held_sum  = cur_sum;
      held_cout = cur_cout;
      for (int k = 0; k < 3; k++) begin
         a = 32'h1111 * (k + 1); b = 32'h2222; cin = 1'b1; in_valid = 1'b1;
         tick();
         check("bp_out_valid", {32'h0, cur_valid}, 33'h1);
         check("bp_sum", {1'b0, cur_sum}, {1'b0, held_sum});
         check("bp_cout", {32'h0, cur_cout}, {32'h0, held_cout});
         check("bp_in_ready", {32'h0, cur_ready}, 33'h0);
      end
      in_valid = 1'b0;
      finish_op();
      check("bp_not_latched", {32'h0, cur_busy}, 33'h0);

      // Reset during the second RUN cycle discards the operation.
      a = 32'h0F0F; b = 32'h0101; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {32'h0, cur_valid}, 33'h0);
      check("mid_rst_sum", {1'b0, cur_sum}, 33'h0);
      check("mid_rst_cout", {32'h0, cur_cout}, 33'h0);
      check("mid_rst_in_ready", {32'h0, cur_ready}, 33'h1);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("no_pulse_after_rst", {32'h0, cur_valid}, 33'h0);
      end
      run_op(32'h1, 32'h2, 1'b0);

      sel = 1;
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      run_op(32'h89ABCDEF, 32'h76543210, 1'b0);

      sel = 2;
      run_op(32'h9, 32'h8, 1'b1);
      run_op(32'h3, 32'h4, 1'b0);

      check("scoreboard_empty", 33'(q.size()), 33'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
